// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states and
// the request legality check used at accept time.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR,
    S_RESP
  } lsu_state_e;

  // Illegal width codes always fault; misalignment faults only when trapping.
  function automatic logic lsu_req_error(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] offset,
                                         input logic       trap_misaligned);
    logic illegal;
    logic misaligned;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_B:  illegal = 1'b0;
      F3_H:  misaligned = offset[0];
      F3_W:  misaligned = (offset != 2'b00);
      F3_BU: illegal = is_store;
      F3_HU: begin
        illegal    = is_store;
        misaligned = offset[0];
      end
      default: illegal = 1'b1;
    endcase
    return illegal | (trap_misaligned & misaligned);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering: extracts and sign/zero-extends a load result from a memory
// word, and merges store data into a memory word for read-modify-write.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_extract,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_byte_base;
  logic [4:0]  w_half_base;

  assign w_byte_base = {i_offset, 3'b000};
  assign w_half_base = {i_offset[1], 4'b0000};
  assign w_byte      = i_word[w_byte_base +: 8];
  assign w_half      = i_word[w_half_base +: 16];

  always_comb begin
    o_extract = i_word;
    case (i_funct3)
      F3_B:    o_extract = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_extract = {24'd0, w_byte};
      F3_H:    o_extract = {{16{w_half[15]}}, w_half};
      F3_HU:   o_extract = {16'd0, w_half};
      default: o_extract = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    case (i_funct3)
      F3_B:    o_merged[w_byte_base +: 8]  = i_wdata[7:0];
      F3_H:    o_merged[w_half_base +: 16] = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one byte-addressed load/store at a time and
// sequences word reads, read-modify-writes and writes against the memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORD_ADDR_BITS  = 30,
  parameter bit TRAP_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_is_store,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_error,
  output logic [31:0] mem_access_addr,
  output logic [31:0] mem_in,
  output logic        mem_write_en,
  output logic        mem_read_en,
  input  logic [31:0] mem_out
);

  lsu_state_e                r_state;
  logic                      r_err;
  logic [2:0]                r_f3;
  logic [1:0]                r_off;
  logic [WORD_ADDR_BITS-1:0] r_waddr;
  logic [31:0]               r_wdata;
  logic [31:0]               r_rdata;

  logic                      w_accept;
  logic                      w_req_err;
  logic [1:0]                w_off_eff;
  logic [31:0]               w_extract;
  logic [31:0]               w_merged;

  assign w_accept  = lsu_req_valid & lsu_req_ready;
  assign w_req_err = lsu_req_error(lsu_is_store, lsu_funct3, lsu_addr[1:0], TRAP_MISALIGNED);

  // Natural-boundary alignment; a no-op for legal aligned requests when trapping.
  always_comb begin
    w_off_eff = lsu_addr[1:0];
    case (lsu_funct3)
      F3_H, F3_HU: w_off_eff = {lsu_addr[1], 1'b0};
      F3_W:        w_off_eff = 2'b00;
      default:     w_off_eff = lsu_addr[1:0];
    endcase
  end

  lsu_byte_lane u_lane (
    .i_word    (mem_out),
    .i_offset  (r_off),
    .i_funct3  (r_f3),
    .i_wdata   (r_wdata),
    .o_extract (w_extract),
    .o_merged  (w_merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_req_err)              r_state <= S_RESP;
            else if (!lsu_is_store)     r_state <= S_RD;
            else if (lsu_funct3 == F3_W) r_state <= S_WR;
            else                        r_state <= S_RMW_RD;
          end
        end
        S_RD:     r_state <= S_RESP;
        S_RMW_RD: r_state <= S_WR;
        S_WR:     r_state <= S_RESP;
        S_RESP:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Request capture and datapath registers; outputs are masked by state instead of reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_accept) begin
      r_err   <= w_req_err;
      r_f3    <= lsu_funct3;
      r_off   <= w_off_eff;
      r_waddr <= lsu_addr[WORD_ADDR_BITS+1:2];
      r_wdata <= lsu_wdata;
      r_rdata <= 32'd0;
    end else if (r_state == S_RD) begin
      r_rdata <= w_extract;
    end else if (r_state == S_RMW_RD) begin
      r_wdata <= w_merged;
    end
  end

  // Strobes are qualified by rst_n so an asserted reset suppresses the pending write edge.
  assign lsu_req_ready   = rst_n & (r_state == S_IDLE);
  assign lsu_resp_valid  = rst_n & (r_state == S_RESP);
  assign lsu_rdata       = lsu_resp_valid ? r_rdata : 32'd0;
  assign lsu_error       = lsu_resp_valid & r_err;
  assign mem_read_en     = rst_n & ((r_state == S_RD) || (r_state == S_RMW_RD));
  assign mem_write_en    = rst_n & (r_state == S_WR);
  assign mem_access_addr = (mem_read_en | mem_write_en) ? 32'(r_waddr) : 32'd0;
  assign mem_in          = mem_write_en ? r_wdata : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses,
// a monitor pops and compares them against each response pulse.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_is_store;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_error;
  logic [31:0] mem_access_addr;
  logic [31:0] mem_in;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_out;

  always #5 clk = ~clk;

  load_store_unit #(.WORD_ADDR_BITS(30), .TRAP_MISALIGNED(1'b1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .lsu_req_valid   (lsu_req_valid),
    .lsu_req_ready   (lsu_req_ready),
    .lsu_is_store    (lsu_is_store),
    .lsu_funct3      (lsu_funct3),
    .lsu_addr        (lsu_addr),
    .lsu_wdata       (lsu_wdata),
    .lsu_resp_valid  (lsu_resp_valid),
    .lsu_rdata       (lsu_rdata),
    .lsu_error       (lsu_error),
    .mem_access_addr (mem_access_addr),
    .mem_in          (mem_in),
    .mem_write_en    (mem_write_en),
    .mem_read_en     (mem_read_en),
    .mem_out         (mem_out)
  );

  // 16-word memory; upper address bits wrap.
  logic [31:0] mem [0:15];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          cyc    = 0;

  assign mem_out = mem[mem_access_addr[3:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_en) begin
      mem[mem_access_addr[3:0]] <= mem_in;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_read_en) rd_cnt <= rd_cnt + 1;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc_cyc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per response pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_checks++;
      if (mem_read_en && mem_write_en) begin
        n_fail++;
        $display("FAIL strobes_exclusive: actual re=1 we=1 required not both");
      end
      if (lsu_resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: actual resp_valid=1 required no response");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_rdata"}, lsu_rdata, e.rdata);
          check({e.name, "_error"}, 32'(lsu_error), 32'(e.err));
          check({e.name, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (lsu_req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (lsu_req_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: actual ready=0 required ready=1 within 20 cycles", name);
    end
  endtask

  task automatic issue(input string name, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat,
                       input int exp_rds, input int exp_wrs);
    exp_t e;
    int   rd0;
    int   wr0;
    @(negedge clk);
    wait_ready(name);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = lat;
    e.name  = name;
    exp_q.push_back(e);
    lsu_req_valid = 1'b1;
    lsu_is_store  = st;
    lsu_funct3    = f3;
    lsu_addr      = a;
    lsu_wdata     = wd;
    @(posedge clk);
    #1;
    acc_cyc       = cyc;
    lsu_req_valid = 1'b0;
    lsu_is_store  = ~st;
    lsu_funct3    = 3'b111;
    lsu_addr      = 32'hFFFF_FFFF;
    lsu_wdata     = 32'hA5A5_A5A5;
    @(negedge clk);
    wait_ready(name);
    check({name, "_reads"}, 32'(rd_cnt - rd0), 32'(exp_rds));
    check({name, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_wrs));
  endtask

  initial begin
    logic [31:0] saved;
    rst_n         = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_is_store  = 1'b0;
    lsu_funct3    = 3'b000;
    lsu_addr      = 32'd0;
    lsu_wdata     = 32'd0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0100_0000 * i;
    mem[1] = 32'h1122_3344;
    mem[2] = 32'hDEAD_BEEF;
    mem[3] = 32'hAABB_CCDD;

    repeat (3) @(negedge clk);
    check("rst_ready",      32'(lsu_req_ready),  32'd0);
    check("rst_resp_valid", 32'(lsu_resp_valid), 32'd0);
    check("rst_rdata",      lsu_rdata,           32'd0);
    check("rst_error",      32'(lsu_error),      32'd0);
    check("rst_mem_addr",   mem_access_addr,     32'd0);
    check("rst_mem_in",     mem_in,              32'd0);
    check("rst_strobes",    32'({mem_read_en, mem_write_en}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready",   32'(lsu_req_ready), 32'd1);
    check("rel_strobes", 32'({mem_read_en, mem_write_en}), 32'd0);

    //    name       st    f3      addr          wdata         exp_rdata     err  lat rd wr
    issue("lw8",     1'b0, 3'b010, 32'h0000_0008, 32'd0,       32'hDEAD_BEEF, 1'b0, 2, 1, 0);
    issue("lb9",     1'b0, 3'b000, 32'h0000_0009, 32'd0,       32'hFFFF_FFBE, 1'b0, 2, 1, 0);
    issue("lbu9",    1'b0, 3'b100, 32'h0000_0009, 32'd0,       32'h0000_00BE, 1'b0, 2, 1, 0);
    issue("lhA",     1'b0, 3'b001, 32'h0000_000A, 32'd0,       32'hFFFF_DEAD, 1'b0, 2, 1, 0);
    issue("lhu8",    1'b0, 3'b101, 32'h0000_0008, 32'd0,       32'h0000_BEEF, 1'b0, 2, 1, 0);
    issue("lbuB",    1'b0, 3'b100, 32'h0000_000B, 32'd0,       32'h0000_00DE, 1'b0, 2, 1, 0);
    issue("lw_wrap", 1'b0, 3'b010, 32'h4000_0008, 32'd0,       32'hDEAD_BEEF, 1'b0, 2, 1, 0);
    issue("sb5",     1'b1, 3'b000, 32'h0000_0005, 32'h0000_0055, 32'd0,      1'b0, 3, 1, 1);
    issue("lw4_sb",  1'b0, 3'b010, 32'h0000_0004, 32'd0,       32'h1122_5544, 1'b0, 2, 1, 0);
    issue("sw4",     1'b1, 3'b010, 32'h0000_0004, 32'hCAFE_F00D, 32'd0,      1'b0, 2, 0, 1);
    issue("lw4_sw",  1'b0, 3'b010, 32'h0000_0004, 32'd0,       32'hCAFE_F00D, 1'b0, 2, 1, 0);
    issue("sh6",     1'b1, 3'b001, 32'h0000_0006, 32'hFFFF_9876, 32'd0,      1'b0, 3, 1, 1);
    issue("lw4_sh",  1'b0, 3'b010, 32'h0000_0004, 32'd0,       32'h9876_F00D, 1'b0, 2, 1, 0);
    issue("lw6_mis", 1'b0, 3'b010, 32'h0000_0006, 32'd0,       32'd0,         1'b1, 1, 0, 0);
    issue("sh3_mis", 1'b1, 3'b001, 32'h0000_0003, 32'h1234,    32'd0,         1'b1, 1, 0, 0);
    issue("ld_f3_3", 1'b0, 3'b011, 32'h0000_0008, 32'd0,       32'd0,         1'b1, 1, 0, 0);
    issue("st_f3_4", 1'b1, 3'b100, 32'h0000_0008, 32'h77,      32'd0,         1'b1, 1, 0, 0);
    check("mem1_final", mem[1], 32'h9876_F00D);

    // Reset while the SH sits in its write cycle: no write, no response.
    saved = mem[3];
    @(negedge clk);
    lsu_req_valid = 1'b1;
    lsu_is_store  = 1'b1;
    lsu_funct3    = 3'b001;
    lsu_addr      = 32'h0000_000C;
    lsu_wdata     = 32'h0000_1234;
    @(posedge clk);
    #1;
    lsu_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_we_before", 32'(mem_write_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_we_in_rst", 32'(mem_write_en), 32'd0);
    repeat (2) @(negedge clk);
    check("abort_resp", 32'(lsu_resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_mem", mem[3], saved);
    issue("lw_after", 1'b0, 3'b010, 32'h0000_000C, 32'd0, saved, 1'b0, 2, 1, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: actual simulation still running required finished");
    $fatal(1, "timeout");
  end

endmodule
